// File: rtl/prio_event_enc.sv
// Sticky-pending event encoder: latches request pulses and streams one binary index per accepted transfer.
// Latency: a request reaches the registered idx/valid output one clock after the edge it arrives on.
// Backpressure: while valid && !ready the output holds and new requests only accumulate in pending.
module prio_event_enc #(
    parameter int N  = 10,
    parameter int RR = 0,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid,
    input  logic         ready,
    output logic         busy,
    output logic         ovf
);

    logic [N-1:0] pend_q, pend_d;
    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         ovf_q, ovf_d;

    logic [N-1:0] cand;
    logic         load;
    logic         found;
    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_mask;

    // Pick one candidate line: lowest index, or first at/above the rotating pointer with wrap.
    always_comb begin
        cand     = pend_q | req;
        load     = !valid_q || ready;
        found    = 1'b0;
        sel_idx  = '0;
        sel_mask = '0;
        if (RR != 0) begin
            // Upper segment [ptr, N-1] first, then wrap to the lower segment.
            for (int i = 0; i < N; i++) begin
                if (!found && cand[i] && (i >= int'(ptr_q))) begin
                    found   = 1'b1;
                    sel_idx = W'(i);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && cand[i]) begin
                found   = 1'b1;
                sel_idx = W'(i);
            end
        end
        // Mask stays zero when the output register is not reloading, so nothing is consumed.
        if (load && found) begin
            for (int i = 0; i < N; i++) begin
                sel_mask[i] = (W'(i) == sel_idx);
            end
        end
    end

    // Next-state for pending set, output register, pointer and merge pulse.
    always_comb begin
        pend_d  = cand & ~sel_mask;
        ovf_d   = |(req & pend_q & ~sel_mask);
        valid_d = valid_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                idx_d = sel_idx;
                if (RR != 0) begin
                    ptr_d = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
                end
            end
        end
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign idx   = idx_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign busy  = valid_q | (|pend_q);

endmodule

// File: tb/tb_prio_event_enc.sv
// Bench for prio_event_enc: fixed-priority and round-robin instances share one stimulus stream.
// Each cycle both instances are compared against a behavioural model; directed tables add explicit values.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_prio_event_enc;

    localparam int N = 10;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         ready;

    logic [W-1:0] idx0, idx1;
    logic         valid0, valid1, busy0, busy1, ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    // Model state per instance: [0] fixed priority, [1] round-robin.
    logic [N-1:0] mp[2];
    bit           mv[2];
    int           mi[2];
    int           mptr[2];
    bit           movf[2];

    prio_event_enc #(.N(N), .RR(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .idx(idx0), .valid(valid0),
        .ready(ready), .busy(busy0), .ovf(ovf0)
    );

    prio_event_enc #(.N(N), .RR(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .idx(idx1), .valid(valid1),
        .ready(ready), .busy(busy1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update(input int m);
        logic [N-1:0] cand;
        int s;
        bit ld;
        if (rst) begin
            mp[m] = '0; mv[m] = 0; mi[m] = 0; mptr[m] = 0; movf[m] = 0;
            return;
        end
        cand = mp[m] | req;
        ld   = !mv[m] || ready;
        s    = -1;
        if (ld) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m == 1) ? (mptr[m] + k) % N : k;
                if (s < 0 && cand[j]) s = j;
            end
        end
        movf[m] = 0;
        for (int b = 0; b < N; b++) begin
            if (b != s && req[b] && mp[m][b]) movf[m] = 1;
        end
        for (int b = 0; b < N; b++) begin
            mp[m][b] = (b == s) ? 1'b0 : (mp[m][b] | req[b]);
        end
        if (ld) begin
            mv[m] = (s >= 0);
            if (s >= 0) begin
                mi[m] = s;
                if (m == 1) mptr[m] = (s + 1) % N;
            end
        end
    endtask

    // One clock: update model, take the edge, compare both instances with the model.
    task automatic cycle();
        model_update(0);
        model_update(1);
        @(posedge clk);
        #1;
        check("m0_valid", int'(valid0), int'(mv[0]));
        check("m0_idx",   int'(idx0),   mi[0]);
        check("m0_busy",  int'(busy0),  int'(mv[0] | (|mp[0])));
        check("m0_ovf",   int'(ovf0),   int'(movf[0]));
        check("m1_valid", int'(valid1), int'(mv[1]));
        check("m1_idx",   int'(idx1),   mi[1]);
        check("m1_busy",  int'(busy1),  int'(mv[1] | (|mp[1])));
        check("m1_ovf",   int'(ovf1),   int'(movf[1]));
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         rdy;
        logic         ev;
        int           ei;
        logic         eb;
        logic         eo;
    } vec_t;

    vec_t tbl[21];
    int   exp_rr[12];

    initial begin
        // Directed expectations for the fixed-priority instance (values after the edge).
        tbl[0]  = '{1'b1, 10'h000, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // reset
        tbl[1]  = '{1'b0, 10'h008, 1'b1, 1'b1, 3, 1'b1, 1'b0}; // single pulse -> idx 3
        tbl[2]  = '{1'b0, 10'h000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 10'h205, 1'b1, 1'b1, 0, 1'b1, 1'b0}; // multi-hot -> 0,2,9
        tbl[4]  = '{1'b0, 10'h000, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 10'h000, 1'b1, 1'b1, 9, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 10'h000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 10'h020, 1'b0, 1'b1, 5, 1'b1, 1'b0}; // idx 5 under ready=0
        tbl[8]  = '{1'b0, 10'h001, 1'b0, 1'b1, 5, 1'b1, 1'b0}; // higher prio arrives, hold
        tbl[9]  = '{1'b0, 10'h000, 1'b0, 1'b1, 5, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 10'h000, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 10'h000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 10'h014, 1'b0, 1'b1, 2, 1'b1, 1'b0}; // idx 2 held, bit 4 pending
        tbl[13] = '{1'b0, 10'h010, 1'b0, 1'b1, 2, 1'b1, 1'b1}; // merge -> ovf
        tbl[14] = '{1'b0, 10'h000, 1'b0, 1'b1, 2, 1'b1, 1'b0}; // ovf one cycle only
        tbl[15] = '{1'b0, 10'h000, 1'b1, 1'b1, 4, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 10'h000, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // 4 presented once
        tbl[17] = '{1'b0, 10'h0E0, 1'b0, 1'b1, 5, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 10'h100, 1'b0, 1'b1, 5, 1'b1, 1'b0}; // three lines pending
        tbl[19] = '{1'b1, 10'h001, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // reset wins over req/ready
        tbl[20] = '{1'b0, 10'h000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        exp_rr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

        for (int m = 0; m < 2; m++) begin
            mp[m] = '0; mv[m] = 0; mi[m] = 0; mptr[m] = 0; movf[m] = 0;
        end
        rst = 1'b1; req = '0; ready = 1'b1;

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; ready = tbl[i].rdy;
            cycle();
            check($sformatf("tbl%0d_valid", i), int'(valid0), int'(tbl[i].ev));
            if (tbl[i].ev) check($sformatf("tbl%0d_idx", i), int'(idx0), tbl[i].ei);
            check($sformatf("tbl%0d_busy", i), int'(busy0), int'(tbl[i].eb));
            check($sformatf("tbl%0d_ovf", i), int'(ovf0), int'(tbl[i].eo));
            if (i == 0) check("reset_idx", int'(idx0), 0);
        end

        // Round-robin: all lines held high for 12 cycles.
        rst = 1'b1; req = '0; ready = 1'b1;
        cycle();
        rst = 1'b0; req = 10'h3FF;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check($sformatf("rr_valid%0d", i), int'(valid1), 1);
            check($sformatf("rr_idx%0d", i), int'(idx1), exp_rr[i]);
        end

        // Reset with pointer advanced: next grant must restart from line 0.
        req = '0; ready = 1'b0;
        cycle();
        rst = 1'b1; req = 10'h0F0;
        cycle();
        check("rr_rst_valid", int'(valid1), 0);
        check("rr_rst_busy", int'(busy1), 0);
        rst = 1'b0; req = 10'h202; ready = 1'b1;
        cycle();
        check("rr_ptr_first", int'(idx1), 1);
        req = '0;
        cycle();
        check("rr_ptr_second", int'(idx1), 9);
        cycle();
        check("rr_drain_busy", int'(busy1), 0);

        // Randomised traffic with sparse requests, random backpressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 149) == 0);
            req   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
